edf_irq_client: RTL

EDF_IRQ_CLIENT -- requirements
Module: edf_irq_client

---
 rtl/edf_irq_client.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/edf_irq_client.sv
// EDF interrupt client: offers the controller's winner to the core when its
// deadline beats the running handler's, acks claims, and tracks a nesting
// stack of absolute deadlines. Offer is registered; take -> ack next cycle.
module edf_irq_client #(
  parameter int NrIrqs  = 4,
  parameter int TsWidth = 24,
  parameter int Depth   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [TsWidth-1:0]            mtime_i,
  input  logic                          irq_valid_i,
  input  logic [$clog2(NrIrqs)-1:0]     irq_id_i,
  input  logic [TsWidth-1:0]            irq_dl_i,
  output logic [$clog2(NrIrqs)-1:0]     irq_id_o,
  output logic                          irq_ack_o,
  output logic                          core_irq_o,
  output logic [$clog2(NrIrqs)-1:0]     core_irq_id_o,
  input  logic                          core_take_i,
  input  logic                          core_mret_i,
  output logic [$clog2(Depth+1)-1:0]    level_o,
  output logic                          err_o
);

  localparam int IdWidth  = $clog2(NrIrqs);
  localparam int LvlWidth = $clog2(Depth + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    ACK   = 2'd2
  } state_e;

  state_e                state_q;
  logic [LvlWidth-1:0]   depth_q;
  logic [TsWidth-1:0]    stack_q [Depth];
  logic [TsWidth-1:0]    abs_q;
  logic [IdWidth-1:0]    core_irq_id_q;
  logic [IdWidth-1:0]    irq_id_q;
  logic                  core_irq_q;
  logic                  ack_q;
  logic                  err_q;

  logic [TsWidth-1:0]    top_abs;
  logic [TsWidth-1:0]    cur_rel;
  logic [TsWidth-1:0]    new_abs;
  logic                  preempt;
  logic                  do_pop;
  logic                  do_push;
  logic [LvlWidth-1:0]   depth_pop;
  logic [LvlWidth-1:0]   depth_d;

  // Select the running handler's absolute deadline (entry depth-1).
  always_comb begin
    top_abs = '0;
    for (int i = 0; i < Depth; i++) begin
      if (LvlWidth'(i + 1) == depth_q) top_abs = stack_q[i];
    end
  end

  // Preemption test and stack bookkeeping; a same-cycle mret pops before the take pushes.
  always_comb begin
    cur_rel   = top_abs - mtime_i;
    new_abs   = irq_dl_i + mtime_i;
    preempt   = irq_valid_i && (depth_q < LvlWidth'(Depth)) &&
                ((depth_q == '0) || (irq_dl_i < cur_rel));
    do_pop    = core_mret_i && (depth_q != '0);
    do_push   = (state_q == OFFER) && core_take_i;
    depth_pop = do_pop ? (depth_q - 1'b1) : depth_q;
    depth_d   = do_push ? (depth_pop + 1'b1) : depth_pop;
  end

  // Deadline stack storage: the push lands just above the post-pop top.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) stack_q[i] <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (do_push && (LvlWidth'(i) == depth_pop)) stack_q[i] <= abs_q;
      end
    end
  end

  // Offer/ack FSM with registered outputs, depth counter and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      depth_q       <= '0;
      abs_q         <= '0;
      core_irq_q    <= 1'b0;
      core_irq_id_q <= '0;
      ack_q         <= 1'b0;
      irq_id_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ack_q   <= 1'b0;
      if (core_mret_i && (depth_q == '0)) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (preempt) begin
            state_q       <= OFFER;
            core_irq_q    <= 1'b1;
            core_irq_id_q <= irq_id_i;
            abs_q         <= new_abs;
          end
        end
        OFFER: begin
          if (core_take_i) begin
            // Claim what was on the wire this cycle, not a fresh re-latch.
            state_q    <= ACK;
            core_irq_q <= 1'b0;
            ack_q      <= 1'b1;
            irq_id_q   <= core_irq_id_q;
          end else if (preempt) begin
            core_irq_id_q <= irq_id_i;
            abs_q         <= new_abs;
          end else begin
            state_q    <= IDLE;
            core_irq_q <= 1'b0;
          end
        end
        ACK: begin
          // Gap cycle so the controller can drop its pending bit first.
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          core_irq_q <= 1'b0;
        end
      endcase
    end
  end

  assign core_irq_o    = core_irq_q;
  assign core_irq_id_o = core_irq_id_q;
  assign irq_ack_o     = ack_q;
  assign irq_id_o      = irq_id_q;
  assign level_o       = depth_q;
  assign err_o         = err_q;

endmodule
